// File: rtl/rlbp_pkg.sv
// ---------------------------------------------------------------------------
// rlbp_pkg
// Shared definitions for the RLBP result-stream receiver: the receiver state
// encoding, default code width, error-counter width and a saturating
// increment helper used by the error counter.
// ---------------------------------------------------------------------------
package rlbp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DONE = 2'd2
  } rlbp_state_e;

  localparam int RLBP_CODE_W_DEFAULT = 8;
  localparam int ERR_CNT_W           = 8;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ERR_CNT_W-1:0] satInc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rlbp_rx_fifo.sv
// ---------------------------------------------------------------------------
// rlbp_rx_fifo
// Code buffer between the serial receiver and the management side.
//
// Build option RLBP_RX_FIFO_EN:
//   defined   : DEPTH-entry circular buffer, pointers carry an extra wrap bit
//               so full and empty can be told apart.
//   undefined : single holding register; DEPTH is ignored and the buffer is
//               full whenever it holds a code.
// In both builds a pop in the same cycle as a push on a full buffer frees the
// slot, so the push is accepted.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write request and code to write
//   i_pop          : consumer takes the head entry (ignored when empty)
//   o_data         : head entry
//   o_full/o_empty : occupancy status
//   o_drop         : push refused because the buffer was full (1-cycle pulse)
// ---------------------------------------------------------------------------
module rlbp_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  logic w_doPush;
  logic w_doPop;

`ifdef RLBP_RX_FIFO_EN

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;

  // Equal pointers mean empty; equal index with differing wrap bits means full.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);
  assign o_drop   = i_push & ~w_doPush;
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  // Storage and pointers. The array is cleared on reset so the head output
  // reads zero before the first code arrives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr[AW-1:0]] <= i_data;
        r_wrPtr                <= r_wrPtr + (AW+1)'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + (AW+1)'(1);
      end
    end
  end

`else

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign o_full   = r_valid;
  assign o_empty  = ~r_valid;
  assign w_doPop  = i_pop & r_valid;
  assign w_doPush = i_push & (~r_valid | w_doPop);
  assign o_drop   = i_push & ~w_doPush;
  assign o_data   = r_data;

  // Single holding register. A push wins over a simultaneous pop, which is
  // what lets a code replace the one being consumed in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_doPush) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (w_doPop) begin
      r_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/rlbp_stream_rx.sv
// ---------------------------------------------------------------------------
// rlbp_stream_rx
// Receiver for the RLBP controller's serial result stream. The slow serial
// clock is oversampled in the wb_clk_i domain; each frame (start strobe,
// CODE_W data bits MSB first, done strobe) is reassembled into one code,
// framing is checked, and good codes are buffered behind a valid/ready
// handshake.
//
// Build option RLBP_RX_FIFO_EN selects a FIFO_DEPTH-entry buffer; without it
// a single holding register is used (see rlbp_rx_fifo).
//
// Ports:
//   wb_clk_i, wb_rst_ni  : system clock, asynchronous active-low reset
//   ser_clk_i            : serial bit clock (asynchronous)
//   ser_start_i          : frame start marker
//   ser_data_i           : serial data, MSB first
//   ser_done_i           : frame end marker
//   clr_i                : clear overflow flag and error counter
//   code_o, code_valid_o : head-of-buffer code and its valid flag
//   code_ready_i         : consumer accepts code_o
//   frame_err_o          : 1-cycle pulse per framing error
//   err_cnt_o            : saturating framing-error count
//   overflow_o           : sticky, a completed code was dropped
//   busy_o               : receiver is inside a frame
// ---------------------------------------------------------------------------
module rlbp_stream_rx
  import rlbp_pkg::*;
#(
  parameter int CODE_W      = RLBP_CODE_W_DEFAULT,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 ser_clk_i,
  input  logic                 ser_start_i,
  input  logic                 ser_data_i,
  input  logic                 ser_done_i,
  input  logic                 clr_i,
  output logic [CODE_W-1:0]    code_o,
  output logic                 code_valid_o,
  input  logic                 code_ready_i,
  output logic                 frame_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CODE_W + 1);

  logic [SYNC_STAGES-1:0] r_syncClk;
  logic [SYNC_STAGES-1:0] r_syncStart;
  logic [SYNC_STAGES-1:0] r_syncData;
  logic [SYNC_STAGES-1:0] r_syncDone;
  logic                   r_clkPrev;

  rlbp_state_e            r_state;
  logic [CODE_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_bitCnt;
  logic                   r_push;
  logic                   r_frameErr;
  logic [ERR_CNT_W-1:0]   r_errCnt;
  logic                   r_overflow;

  logic                   w_sClk;
  logic                   w_start;
  logic                   w_data;
  logic                   w_done;
  logic                   w_strobe;
  logic                   w_err;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_drop;

  // Identical flop chains on all four serial inputs keep start/data/done
  // aligned with the synchronized clock they were launched against.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_syncClk   <= '0;
      r_syncStart <= '0;
      r_syncData  <= '0;
      r_syncDone  <= '0;
      r_clkPrev   <= 1'b0;
    end else begin
      r_syncClk   <= {r_syncClk[SYNC_STAGES-2:0],   ser_clk_i};
      r_syncStart <= {r_syncStart[SYNC_STAGES-2:0], ser_start_i};
      r_syncData  <= {r_syncData[SYNC_STAGES-2:0],  ser_data_i};
      r_syncDone  <= {r_syncDone[SYNC_STAGES-2:0],  ser_done_i};
      r_clkPrev   <= w_sClk;
    end
  end

  assign w_sClk   = r_syncClk[SYNC_STAGES-1];
  assign w_start  = r_syncStart[SYNC_STAGES-1];
  assign w_data   = r_syncData[SYNC_STAGES-1];
  assign w_done   = r_syncDone[SYNC_STAGES-1];
  assign w_strobe = w_sClk & ~r_clkPrev;

  // A framing error is any start or done marker out of place while a frame
  // is open, or a missing done after the last data bit. Start together with
  // done in IDLE is a legal frame start and not an error.
  assign w_err = w_strobe &
                 (((r_state == SHIFT)     & (w_start | w_done)) |
                  ((r_state == WAIT_DONE) & (w_start | ~w_done)));

  // Frame state machine with its registered outputs: push request, error
  // pulse and the saturating error counter. Start always restarts the frame,
  // so it takes priority over done and data in every state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_push     <= 1'b0;
      r_frameErr <= 1'b0;
      r_errCnt   <= '0;
    end else begin
      r_push     <= 1'b0;
      r_frameErr <= w_err;

      if (clr_i) begin
        r_errCnt <= w_err ? ERR_CNT_W'(1) : '0;
      end else if (w_err) begin
        r_errCnt <= satInc(r_errCnt);
      end

      if (w_strobe) begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_shift  <= '0;
              r_bitCnt <= '0;
              r_state  <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_start) begin
              r_shift  <= '0;
              r_bitCnt <= '0;
            end else if (w_done) begin
              r_state <= IDLE;
            end else begin
              r_shift  <= {r_shift[CODE_W-2:0], w_data};
              r_bitCnt <= r_bitCnt + CNT_W'(1);
              if (r_bitCnt == CNT_W'(CODE_W - 1)) begin
                r_state <= WAIT_DONE;
              end
            end
          end
          WAIT_DONE: begin
            if (w_start) begin
              r_shift  <= '0;
              r_bitCnt <= '0;
              r_state  <= SHIFT;
            end else begin
              r_push  <= w_done;
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Sticky overflow flag. A drop in the same cycle as a clear still sets it,
  // so a lost code is never hidden.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop | (r_overflow & ~clr_i);
    end
  end

  assign w_pop = ~w_empty & code_ready_i;

  // The shift register is untouched until the next start strobe, which is
  // at least one full serial period away, so it can feed the buffer directly
  // in the push cycle.
  rlbp_rx_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_push  (r_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (code_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign code_valid_o = ~w_empty;
  assign frame_err_o  = r_frameErr;
  assign err_cnt_o    = r_errCnt;
  assign overflow_o   = r_overflow;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_rlbp_stream_rx.sv
// ---------------------------------------------------------------------------
// tb_rlbp_stream_rx
// Drives serial frames into rlbp_stream_rx at wb_clk = 8x ser_clk and checks
// the buffered codes, error counter and flags against a frame-level model:
// a good frame appends its code to a bounded queue, a malformed frame adds
// one saturating error, and a pop removes the queue head.
// ---------------------------------------------------------------------------
module tb_rlbp_stream_rx;

  localparam int CODE_W      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;
`ifdef RLBP_RX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic              wb_clk_i     = 1'b0;
  logic              wb_rst_ni    = 1'b0;
  logic              ser_clk_i    = 1'b0;
  logic              ser_start_i  = 1'b0;
  logic              ser_data_i   = 1'b0;
  logic              ser_done_i   = 1'b0;
  logic              clr_i        = 1'b0;
  logic              code_ready_i = 1'b0;
  logic [CODE_W-1:0] code_o;
  logic              code_valid_o;
  logic              frame_err_o;
  logic [7:0]        err_cnt_o;
  logic              overflow_o;
  logic              busy_o;

  int testCount = 0;
  int failCount = 0;
  int errPulses = 0;

  logic [CODE_W-1:0] modelQ[$];
  int                modelErr = 0;
  logic              modelOvf = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  rlbp_stream_rx #(
    .CODE_W      (CODE_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_ni    (wb_rst_ni),
    .ser_clk_i    (ser_clk_i),
    .ser_start_i  (ser_start_i),
    .ser_data_i   (ser_data_i),
    .ser_done_i   (ser_done_i),
    .clr_i        (clr_i),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i),
    .frame_err_o  (frame_err_o),
    .err_cnt_o    (err_cnt_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o)
  );

  // Count every cycle the error pulse is high, so pulse width and count
  // can both be checked against the number of malformed frames.
  always @(posedge wb_clk_i) begin
    if (frame_err_o === 1'b1) errPulses++;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelPush(input logic [CODE_W-1:0] c);
    if (modelQ.size() < CAP) modelQ.push_back(c);
    else modelOvf = 1'b1;
  endtask

  task automatic modelError();
    if (modelErr < 255) modelErr++;
  endtask

  // One serial bit slot: markers change with the falling edge, then a high
  // phase during which the receiver strobes them.
  task automatic applyStimulus(input logic s, input logic d, input logic dn);
    ser_clk_i   = 1'b0;
    ser_start_i = s;
    ser_data_i  = d;
    ser_done_i  = dn;
    repeat (HALF) @(negedge wb_clk_i);
    ser_clk_i = 1'b1;
    repeat (HALF) @(negedge wb_clk_i);
  endtask

  task automatic idleGap();
    ser_clk_i   = 1'b0;
    ser_start_i = 1'b0;
    ser_data_i  = 1'b0;
    ser_done_i  = 1'b0;
    repeat (6) @(negedge wb_clk_i);
  endtask

  // Done slot. mode 0: plain. mode 1: raise code_ready_i for exactly the
  // push cycle (SYNC_STAGES+1 negedges after the serial rising edge).
  // mode 2: measure cycles from the serial rising edge to code_valid_o.
  task automatic doneSlot(input int mode);
    int lat;
    ser_clk_i   = 1'b0;
    ser_start_i = 1'b0;
    ser_data_i  = 1'b0;
    ser_done_i  = 1'b1;
    repeat (HALF) @(negedge wb_clk_i);
    ser_clk_i = 1'b1;
    if (mode == 1) begin
      repeat (SYNC_STAGES + 1) @(negedge wb_clk_i);
      checkOutput("head_at_push", code_o, modelQ[0]);
      code_ready_i = 1'b1;
      @(negedge wb_clk_i);
      code_ready_i = 1'b0;
      repeat (HALF - SYNC_STAGES - 2) @(negedge wb_clk_i);
    end else if (mode == 2) begin
      lat = 0;
      while (code_valid_o !== 1'b1 && lat < 8) begin
        @(negedge wb_clk_i);
        lat++;
      end
      checkOutput("valid_latency_ok", (lat >= 3 && lat <= 5), 1);
      if (lat < HALF) repeat (HALF - lat) @(negedge wb_clk_i);
    end else begin
      repeat (HALF) @(negedge wb_clk_i);
    end
  endtask

  task automatic sendBody(input logic [CODE_W-1:0] c, input int mode);
    for (int i = CODE_W - 1; i >= 0; i--) applyStimulus(1'b0, c[i], 1'b0);
    doneSlot(mode);
    idleGap();
    if (mode == 1) void'(modelQ.pop_front());
    modelPush(c);
  endtask

  task automatic sendGood(input logic [CODE_W-1:0] c, input int mode);
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendBody(c, mode);
  endtask

  task automatic sendEarlyDone(input int n);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("busy_mid_frame", busy_o, 1);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleGap();
    modelError();
  endtask

  // Abort after n bits with a fresh start marker (optionally carrying done
  // as well), then complete a full frame carrying c.
  task automatic sendRestart(input int n, input logic [CODE_W-1:0] c, input logic withDone);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b0, withDone);
    modelError();
    sendBody(c, 0);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_valid"}, code_valid_o, (modelQ.size() > 0));
    if (modelQ.size() > 0) checkOutput({tag, "_code"}, code_o, modelQ[0]);
    checkOutput({tag, "_errcnt"}, err_cnt_o, modelErr);
    checkOutput({tag, "_overflow"}, overflow_o, modelOvf);
    checkOutput({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic popOne(input string tag);
    checkOutput({tag, "_pop_valid"}, code_valid_o, 1);
    checkOutput({tag, "_pop_code"}, code_o, modelQ[0]);
    code_ready_i = 1'b1;
    @(negedge wb_clk_i);
    code_ready_i = 1'b0;
    void'(modelQ.pop_front());
  endtask

  task automatic drainAll(input string tag);
    while (modelQ.size() > 0) popOne(tag);
    checkOutput({tag, "_drained"}, code_valid_o, 0);
  endtask

  task automatic pulseClear();
    clr_i = 1'b1;
    @(negedge wb_clk_i);
    clr_i = 1'b0;
    modelErr = 0;
    modelOvf = 1'b0;
    checkOutput("clr_errcnt", err_cnt_o, 0);
    checkOutput("clr_overflow", overflow_o, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_code"}, code_o, 0);
    checkOutput({tag, "_valid"}, code_valid_o, 0);
    checkOutput({tag, "_frame_err"}, frame_err_o, 0);
    checkOutput({tag, "_errcnt"}, err_cnt_o, 0);
    checkOutput({tag, "_overflow"}, overflow_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    int p0;
    logic [CODE_W-1:0] c;

    // Reset values.
    repeat (3) @(negedge wb_clk_i);
    checkResetOutputs("reset");
    wb_rst_ni = 1'b1;
    repeat (3) @(negedge wb_clk_i);

    // Single frame 0xA5 with valid-latency measurement.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendBody(8'hA5, 2);
    checkState("a5");
    drainAll("a5");

    // Five back-to-back frames with no consumer: overflow past capacity.
    for (int i = 1; i <= 5; i++) sendGood(CODE_W'(i), 0);
    checkState("burst");
    drainAll("burst");
    pulseClear();

    // done after 5 bits, then a good 0x3C.
    p0 = errPulses;
    sendEarlyDone(5);
    checkOutput("early_done_pulses", errPulses - p0, 1);
    checkState("early_done");
    sendGood(8'h3C, 0);
    checkState("after_err_3c");
    drainAll("after_err_3c");
    pulseClear();

    // start reasserted after 3 bits, then a full 0x7E.
    p0 = errPulses;
    sendRestart(3, 8'h7E, 1'b0);
    checkOutput("restart_pulses", errPulses - p0, 1);
    checkState("restart_7e");
    drainAll("restart_7e");

    // start and done together mid-frame: restart wins, error still counted.
    p0 = errPulses;
    sendRestart(5, 8'h96, 1'b1);
    checkOutput("start_done_pulses", errPulses - p0, 1);
    checkState("start_done");
    drainAll("start_done");
    pulseClear();

    // Full buffer, pop exactly in the push cycle: no overflow, order kept.
    for (int i = 0; i < CAP; i++) sendGood(CODE_W'($urandom), 0);
    checkState("fill");
    sendGood(CODE_W'($urandom), 1);
    checkOutput("pop_push_occupancy_full", (modelQ.size() == CAP), 1);
    checkState("pop_push");
    drainAll("pop_push");

    // Reset mid-frame, then a good 0xC3.
    sendGood(8'h11, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    wb_rst_ni = 1'b0;
    @(negedge wb_clk_i);
    checkResetOutputs("midreset");
    modelQ.delete();
    modelErr = 0;
    modelOvf = 1'b0;
    wb_rst_ni = 1'b1;
    idleGap();
    sendGood(8'hC3, 0);
    checkState("after_reset_c3");
    drainAll("after_reset_c3");

    // 301 framing errors: repeated starts, then a stray done. Saturates.
    p0 = errPulses;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      modelError();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    modelError();
    idleGap();
    checkOutput("sat_pulses", errPulses - p0, 301);
    checkState("saturate");
    pulseClear();

    // Randomized mix of good, early-done and restarted frames with random
    // consumer activity.
    for (int k = 0; k < 12; k++) begin
      c = CODE_W'($urandom);
      case ($urandom_range(0, 2))
        0:       sendGood(c, 0);
        1:       sendEarlyDone(int'($urandom_range(0, CODE_W - 1)));
        default: sendRestart(int'($urandom_range(0, CODE_W - 1)), c, 1'($urandom));
      endcase
      checkState("rand");
      if ($urandom_range(0, 1) == 1 && modelQ.size() > 0) popOne("rand");
    end
    drainAll("rand_end");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rlbp_stream_rx.md
# rlbp_stream_rx

Receiver for the serial result stream (clock, start, data, done) the RLBP pixel controller emits. It runs in the Wishbone clock domain and oversamples the slow serial clock. It reassembles each frame into a CODE_W-bit LBP code, checks framing, and buffers the codes for the management side behind a valid/ready handshake. It sits in the user area next to the RLBP controller and the analog SystemLevel macro, and closes the loop from the analog readout back to firmware.

## Interface
- CODE_W, 8: data bits per frame (LBP code width), 2..16.
- FIFO_DEPTH, 4: code buffer entries, power of two, ≥2; used only when the FIFO is compiled in.
- SYNC_STAGES, 2: synchronizer flops on each serial input, ≥2.
- wb_clk_i  in  1  system clock; all logic is on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- ser_clk_i  in  1  serial bit clock from the controller; asynchronous to wb_clk_i.
- ser_start_i  in  1  frame start marker.
- ser_data_i  in  1  serial data, MSB first.
- ser_done_i  in  1  frame end marker.
- clr_i  in  1  synchronous clear of the sticky flags and the error counter.
- code_o  out  CODE_W  head-of-buffer code.
- code_valid_o  out  1  code_o holds a code.
- code_ready_i  in  1  consumer accepts code_o when code_valid_o is high.
- frame_err_o  out  1  one-cycle pulse on each framing error.
- err_cnt_o  out  8  saturating framing-error count.
- overflow_o  out  1  sticky flag: a completed code was dropped because the buffer was full.
- busy_o  out  1  receiver is inside a frame.

## Operation
- The transmitter changes ser_start_i, ser_data_i and ser_done_i on the falling edge of ser_clk_i.
- All four serial inputs pass through identical SYNC_STAGES flop chains, so their relative alignment is kept.
- Bit strobe: a 0→1 transition on the synchronized ser_clk, detected with one extra register. The start, data and done levels used for a strobe are the synchronized values in the same cycle.
- State machine:
  - IDLE: on a strobe with start=1, clear the shift register, set bitcnt=0 and go to SHIFT.
  - SHIFT: on each strobe, shift data in at the LSB (MSB-first order) and increment bitcnt. After the CODE_W-th bit, go to WAIT_DONE.
  - WAIT_DONE: on the next strobe:
    - done=1: the frame is complete. Push the code and go to IDLE.
    - done=0: framing error. Go to IDLE.
- Framing errors:
  - done=1 seen in SHIFT: error, go to IDLE.
  - start=1 seen in SHIFT or WAIT_DONE: error, restart the frame (stay in or return to SHIFT with bitcnt=0).
  - start=1 and done=1 on the same strobe: start wins, but the error is still flagged if the receiver is mid-frame.
- On any error: frame_err_o pulses for 1 cycle and err_cnt_o increments, saturating at 255. No code is pushed.
- Push:
  - If the buffer has space, the code is written.
  - If the buffer is full, the code is dropped and overflow_o is set; existing entries are kept.
  - A pop (code_valid_o & code_ready_i) in the same cycle as a push on a full buffer frees a slot, so the push succeeds and there is no overflow.
- clr_i clears overflow_o and err_cnt_o next cycle. If an error occurs in the same cycle as clr_i, err_cnt_o becomes 1.
- busy_o = (state != IDLE).

## Timing
- Values after reset:
  - state IDLE and all synchronizers 0.
  - code_o=0, code_valid_o=0, frame_err_o=0, err_cnt_o=0, overflow_o=0, busy_o=0.
- Strobe latency: SYNC_STAGES+1 wb_clk cycles after the ser_clk rising edge, ±1 cycle of sampling uncertainty.
- Push occurs in the cycle after the done strobe.
- code_valid_o rises in the cycle after the push into an empty buffer.
- code_o is stable while code_valid_o=1 and code_ready_i=0.
- Throughput: one pop per cycle.
- Constraint: wb_clk_i must run at ≥4× ser_clk_i, and each ser_clk phase must last ≥2 wb_clk cycles. Below this, bits are lost; no detection is required.
- Reset asserted mid-frame aborts the frame immediately. No error is counted.

## Configuration
- RLBP_RX_FIFO_EN defined: a FIFO_DEPTH-entry circular buffer holds codes.
  - Pointers are log2(FIFO_DEPTH)+1 bits, with the wrap bit used to tell full from empty.
  - code_o is the registered head entry.
- RLBP_RX_FIFO_EN undefined: a single holding register is used and FIFO_DEPTH is ignored.
  - The buffer is full whenever code_valid_o=1.
  - The simultaneous pop+push rule still applies.

## Structure
- Shared package rlbp_pkg holds:
  - state enum {IDLE, SHIFT, WAIT_DONE};
  - RLBP_CODE_W_DEFAULT=8;
  - ERR_CNT_W=8.
- The buffer is sub-module rlbp_rx_fifo (width, depth; push/pop/full/empty). In the non-FIFO build it degenerates to the 1-entry holding register.
- Synchronizers are instantiated inline per input.

## Test plan
- Frame 0xA5 (start, 8 bits, done) at wb_clk = 8×ser_clk → one push; code_o=0xA5; code_valid_o rises about 3 cycles after the done edge; err_cnt_o=0.
- Five back-to-back frames 0x01..0x05 with code_ready_i=0, FIFO build, depth 4 → codes 0x01..0x04 retained; overflow_o=1; draining yields 0x01..0x04 in order.
- done asserted after 5 bits → frame_err_o pulses once; err_cnt_o=1; no push; next valid frame 0x3C is received correctly.
- start reasserted after 3 bits, followed by a full 0x7E frame → err_cnt_o=1; code_o=0x7E.
- Buffer full, with code_ready_i=1 exactly in the push cycle → no overflow; occupancy unchanged; order preserved.
- wb_rst_ni pulsed low after 4 bits, then a frame 0xC3 → all outputs reset; 0xC3 is received; err_cnt_o=0. Then 300 errors → err_cnt_o=255; clr_i → 0.
